// File: rtl/rs_age_station.sv
// Age-ordered reservation station: dispatch into the lowest free slot, wake operands from the
// CDB channels, and issue the oldest ready entry over a valid/ready handshake.
module rs_age_station #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4,
  parameter int N_CDB = 2,
  parameter int OP_W  = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [ROB_W-1:0]           disp_rob_id,
  input  logic [31:0]                disp_Vj,
  input  logic [31:0]                disp_Vk,
  input  logic [ROB_W-1:0]           disp_Qj,
  input  logic [ROB_W-1:0]           disp_Qk,
  input  logic [N_CDB-1:0]           cdb_valid,
  input  logic [N_CDB*ROB_W-1:0]     cdb_rob_id,
  input  logic [N_CDB*32-1:0]        cdb_value,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_op,
  output logic [ROB_W-1:0]           issue_rob_id,
  output logic [31:0]                issue_Vj,
  output logic [31:0]                issue_Vk,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       one_vacancy
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy;
  logic [OP_W-1:0]  op_q  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  // older[i][j] set means entry j was allocated before entry i
  logic [DEPTH-1:0] older [DEPTH];

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] wake_j;
  logic [DEPTH-1:0] wake_k;
  logic [31:0]      wval_j [DEPTH];
  logic [31:0]      wval_k [DEPTH];
  logic             byp_j;
  logic             byp_k;
  logic [31:0]      byp_vj;
  logic [31:0]      byp_vk;
  logic [IW-1:0]    alloc_idx;
  logic             issue_en;
  logic             disp_fire;
  logic             issue_fire;

  // Lowest channel wins when several carry the same tag; tag 0 never matches.
  function automatic logic [32:0] cdb_lookup(input logic [ROB_W-1:0]       tag,
                                             input logic [N_CDB-1:0]       v,
                                             input logic [N_CDB*ROB_W-1:0] ids,
                                             input logic [N_CDB*32-1:0]    vals);
    logic [32:0] r;
    r = '0;
    for (int c = N_CDB-1; c >= 0; c--)
      if (v[c] && (tag != '0) && (ids[c*ROB_W +: ROB_W] == tag))
        r = {1'b1, vals[c*32 +: 32]};
    return r;
  endfunction

  always_comb begin
    wake_j = '0;
    wake_k = '0;
    for (int i = 0; i < DEPTH; i++) begin
      {wake_j[i], wval_j[i]} = cdb_lookup(qj_q[i], cdb_valid, cdb_rob_id, cdb_value);
      {wake_k[i], wval_k[i]} = cdb_lookup(qk_q[i], cdb_valid, cdb_rob_id, cdb_value);
    end
    {byp_j, byp_vj} = cdb_lookup(disp_Qj, cdb_valid, cdb_rob_id, cdb_value);
    {byp_k, byp_vk} = cdb_lookup(disp_Qk, cdb_valid, cdb_rob_id, cdb_value);
  end

  // Oldest-ready pick: an entry is granted when no ready entry is older than it.
  always_comb begin
    rdy      = '0;
    grant    = '0;
    issue_en = !rst_in && !flush_in;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    for (int i = 0; i < DEPTH; i++)
      grant[i] = issue_en && rdy[i] && ((older[i] & rdy) == '0);
  end

  always_comb begin
    issue_op     = '0;
    issue_rob_id = '0;
    issue_Vj     = '0;
    issue_Vk     = '0;
    for (int i = 0; i < DEPTH; i++)
      if (grant[i]) begin
        issue_op     = op_q[i];
        issue_rob_id = rob_q[i];
        issue_Vj     = vj_q[i];
        issue_Vk     = vk_q[i];
      end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy[i]) alloc_idx = IW'(i);
  end

  assign issue_valid = |grant;
  assign full        = (count == CW'(DEPTH));
  assign one_vacancy = (count == CW'(DEPTH-1));
  assign disp_ready  = !full && !rst_in;
  assign disp_fire   = disp_valid && disp_ready && !flush_in;
  assign issue_fire  = issue_valid && issue_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        older[i] <= '0;
      end
    end else if (flush_in) begin
      busy  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && wake_j[i]) begin
          vj_q[i] <= wval_j[i];
          qj_q[i] <= '0;
        end
        if (busy[i] && wake_k[i]) begin
          vk_q[i] <= wval_k[i];
          qk_q[i] <= '0;
        end
        if (issue_fire && grant[i])
          busy[i] <= 1'b0;
      end

      // A reused slot must stop looking older to every other entry, hence the column clear.
      if (disp_fire) begin
        for (int k = 0; k < DEPTH; k++)
          older[k][alloc_idx] <= 1'b0;
        older[alloc_idx]  <= busy & ~(issue_fire ? grant : '0);
        busy[alloc_idx]   <= 1'b1;
        op_q[alloc_idx]   <= disp_op;
        rob_q[alloc_idx]  <= disp_rob_id;
        vj_q[alloc_idx]   <= byp_j ? byp_vj : disp_Vj;
        vk_q[alloc_idx]   <= byp_k ? byp_vk : disp_Vk;
        qj_q[alloc_idx]   <= byp_j ? '0 : disp_Qj;
        qk_q[alloc_idx]   <= byp_k ? '0 : disp_Qk;
      end

      if (disp_fire && !issue_fire)
        count <= count + CW'(1);
      else if (!disp_fire && issue_fire)
        count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_rs_age_station.sv
// Bench for rs_age_station: directed vector table, fill/flush sequence, then randomized
// traffic checked against an age-ordered queue model.
module tb_rs_age_station;
  localparam int DEPTH = 16;
  localparam int ROB_W = 4;
  localparam int N_CDB = 2;
  localparam int OP_W  = 8;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        disp_valid;
  logic        disp_ready;
  logic [7:0]  disp_op;
  logic [3:0]  disp_rob_id;
  logic [31:0] disp_Vj;
  logic [31:0] disp_Vk;
  logic [3:0]  disp_Qj;
  logic [3:0]  disp_Qk;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_rob_id;
  logic [63:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [7:0]  issue_op;
  logic [3:0]  issue_rob_id;
  logic [31:0] issue_Vj;
  logic [31:0] issue_Vk;
  logic [4:0]  count;
  logic        full;
  logic        one_vacancy;

  int tests_run    = 0;
  int tests_failed = 0;

  rs_age_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .N_CDB(N_CDB), .OP_W(OP_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_rob_id(disp_rob_id), .disp_Vj(disp_Vj), .disp_Vk(disp_Vk),
    .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rob_id(issue_rob_id), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .count(count), .full(full), .one_vacancy(one_vacancy)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        dv;
    logic [7:0]  op;
    logic [3:0]  rob, qj, qk;
    logic [31:0] vj, vk;
    logic        ir, fl;
    logic [1:0]  cv;
    logic [3:0]  t0, t1;
    logic [31:0] d0, d1;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_iv;
    logic [3:0]  e_rob;
    logic [31:0] e_vj, e_vk;
    int          e_cnt;
  } vec_t;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rob, qj, qk;
    logic [31:0] vj, vk;
  } ent_t;

  vec_t vecs[$];
  // Entries in dispatch (age) order; oldest at index 0
  ent_t mq[$];

  function automatic stim_t st(input logic dv, input logic [3:0] rob, input logic [3:0] qj,
                               input logic [3:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                               input logic ir, input logic [1:0] cv, input logic [3:0] t0,
                               input logic [31:0] d0, input logic [3:0] t1, input logic [31:0] d1);
    stim_t s;
    s.dv = dv; s.op = {4'h8, rob}; s.rob = rob; s.qj = qj; s.qk = qk;
    s.vj = vj; s.vk = vk; s.ir = ir; s.fl = 1'b0;
    s.cv = cv; s.t0 = t0; s.d0 = d0; s.t1 = t1; s.d1 = d1;
    return s;
  endfunction

  task automatic add_vec(input stim_t s, input logic iv, input logic [3:0] rob,
                         input logic [31:0] vj, input logic [31:0] vk, input int cnt);
    vec_t v;
    v.s = s; v.e_iv = iv; v.e_rob = rob; v.e_vj = vj; v.e_vk = vk; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input stim_t s);
    disp_valid  = s.dv;
    disp_op     = s.op;
    disp_rob_id = s.rob;
    disp_Qj     = s.qj;
    disp_Qk     = s.qk;
    disp_Vj     = s.vj;
    disp_Vk     = s.vk;
    issue_ready = s.ir;
    flush_in    = s.fl;
    cdb_valid   = s.cv;
    cdb_rob_id  = {s.t1, s.t0};
    cdb_value   = {s.d1, s.d0};
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_pick();
    foreach (mq[i])
      if (mq[i].qj == 4'd0 && mq[i].qk == 4'd0) return i;
    return -1;
  endfunction

  function automatic logic [32:0] model_cdb(input logic [3:0] tag, input stim_t s);
    logic [3:0]  t [2];
    logic [31:0] d [2];
    t[0] = s.t0; t[1] = s.t1; d[0] = s.d0; d[1] = s.d1;
    for (int c = 0; c < N_CDB; c++)
      if (s.cv[c] && tag != 4'd0 && t[c] == tag) return {1'b1, d[c]};
    return 33'd0;
  endfunction

  task automatic model_check(input stim_t s, input logic rst);
    int   p;
    logic exp_iv;
    p = model_pick();
    exp_iv = (p >= 0) && !rst && !s.fl;
    check_output("m_count", 32'(count), 32'(mq.size()));
    check_output("m_disp_ready", 32'(disp_ready), 32'(!rst && mq.size() < DEPTH));
    check_output("m_full", 32'(full), 32'(mq.size() == DEPTH));
    check_output("m_one_vacancy", 32'(one_vacancy), 32'(mq.size() == DEPTH-1));
    check_output("m_issue_valid", 32'(issue_valid), 32'(exp_iv));
    if (exp_iv) begin
      check_output("m_issue_op", 32'(issue_op), 32'(mq[p].op));
      check_output("m_issue_rob", 32'(issue_rob_id), 32'(mq[p].rob));
      check_output("m_issue_vj", issue_Vj, mq[p].vj);
      check_output("m_issue_vk", issue_Vk, mq[p].vk);
    end
  endtask

  task automatic model_edge(input stim_t s, input logic rst);
    int          p;
    logic        accept_d;
    logic [32:0] m;
    ent_t        e;
    if (rst || s.fl) begin
      mq.delete();
      return;
    end
    p = model_pick();
    accept_d = s.dv && (mq.size() < DEPTH);
    foreach (mq[i]) begin
      m = model_cdb(mq[i].qj, s);
      if (m[32]) begin mq[i].vj = m[31:0]; mq[i].qj = 4'd0; end
      m = model_cdb(mq[i].qk, s);
      if (m[32]) begin mq[i].vk = m[31:0]; mq[i].qk = 4'd0; end
    end
    if (p >= 0 && s.ir) mq.delete(p);
    if (accept_d) begin
      e.op = s.op; e.rob = s.rob; e.qj = s.qj; e.qk = s.qk; e.vj = s.vj; e.vk = s.vk;
      m = model_cdb(s.qj, s);
      if (m[32]) begin e.vj = m[31:0]; e.qj = 4'd0; end
      m = model_cdb(s.qk, s);
      if (m[32]) begin e.vk = m[31:0]; e.qk = 4'd0; end
      mq.push_back(e);
    end
  endtask

  task automatic model_step(input stim_t s, input logic rst);
    rst_in = rst;
    apply_stimulus(s);
    @(negedge clk_in);
    model_check(s, rst);
    model_edge(s, rst);
    @(posedge clk_in);
    #1;
  endtask

  function automatic stim_t rand_stim(input int ir_pct);
    stim_t s;
    s.dv  = ($urandom_range(99) < 60);
    s.op  = 8'($urandom);
    s.rob = 4'($urandom);
    s.qj  = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    s.qk  = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
    s.vj  = $urandom;
    s.vk  = $urandom;
    s.ir  = ($urandom_range(99) < ir_pct);
    s.fl  = ($urandom_range(49) == 0);
    s.cv  = 2'($urandom);
    s.t0  = 4'($urandom);
    s.t1  = 4'($urandom);
    s.d0  = $urandom;
    s.d1  = $urandom;
    return s;
  endfunction

  initial begin
    stim_t idle;
    stim_t s;
    idle = st(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    rst_in = 1'b1;
    apply_stimulus(idle);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_output("rst_disp_ready", 32'(disp_ready), 32'd0);
    check_output("rst_issue_valid", 32'(issue_valid), 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check_output("post_rst_disp_ready", 32'(disp_ready), 32'd1);
    check_output("post_rst_issue_valid", 32'(issue_valid), 32'd0);
    check_output("post_rst_count", 32'(count), 32'd0);
    check_output("post_rst_full", 32'(full), 32'd0);
    check_output("post_rst_one_vacancy", 32'(one_vacancy), 32'd0);
    check_output("post_rst_issue_op", 32'(issue_op), 32'd0);
    check_output("post_rst_issue_rob", 32'(issue_rob_id), 32'd0);
    check_output("post_rst_issue_vj", issue_Vj, 32'd0);
    check_output("post_rst_issue_vk", issue_Vk, 32'd0);
    @(posedge clk_in);
    #1;

    // Basic dispatch/issue round trip
    add_vec(st(1, 3, 0, 0, 5, 7, 0, 2'b00, 0, 0, 0, 0),       0, 0, 0, 0, 0);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 3, 5, 7, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);
    // A waits on tag 5, B ready; B issues while ch1 wakes A
    add_vec(st(1, 1, 5, 0, 0, 32'h11, 0, 2'b00, 0, 0, 0, 0),  0, 0, 0, 0, 0);
    add_vec(st(1, 2, 0, 0, 32'h22, 32'h33, 0, 2'b00, 0, 0, 0, 0), 0, 0, 0, 0, 1);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 5, 32'hAA),  1, 2, 32'h22, 32'h33, 2);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 1, 32'hAA, 32'h11, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);
    // Reused slot 0 holds the youngest entry, so it issues last
    add_vec(st(1, 8, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0),       0, 0, 0, 0, 0);
    add_vec(st(1, 9, 7, 0, 0, 9, 0, 2'b00, 0, 0, 0, 0),       1, 8, 1, 1, 1);
    add_vec(st(1, 10, 7, 0, 0, 10, 1, 2'b00, 0, 0, 0, 0),     1, 8, 1, 1, 2);
    add_vec(st(1, 11, 7, 0, 0, 11, 0, 2'b00, 0, 0, 0, 0),     0, 0, 0, 0, 2);
    add_vec(st(0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 32'h77, 0, 0),  0, 0, 0, 0, 3);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 9, 32'h77, 9, 3);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 10, 32'h77, 10, 2);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 11, 32'h77, 11, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);
    // Same-cycle dispatch bypass on Qk
    add_vec(st(1, 12, 0, 9, 3, 0, 0, 2'b01, 9, 32'h1234, 0, 0), 0, 0, 0, 0, 0);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 12, 3, 32'h1234, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);
    // Both channels carry tag 4: channel 0 wins
    add_vec(st(1, 13, 4, 0, 0, 32'h13, 0, 2'b00, 0, 0, 0, 0), 0, 0, 0, 0, 0);
    add_vec(st(0, 0, 0, 0, 0, 0, 0, 2'b11, 4, 32'hC0, 4, 32'hC1), 0, 0, 0, 0, 1);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 13, 32'hC0, 32'h13, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);
    // CDB tag 0 must never overwrite a present operand
    add_vec(st(1, 14, 0, 0, 32'h55, 32'h66, 0, 2'b01, 0, 32'hDEAD, 0, 0), 0, 0, 0, 0, 0);
    add_vec(st(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 32'hBEEF, 0, 0), 1, 14, 32'h55, 32'h66, 1);
    add_vec(st(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0),       1, 14, 32'h55, 32'h66, 1);
    add_vec(idle,                                             0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      apply_stimulus(v.s);
      @(negedge clk_in);
      check_output($sformatf("v%0d_issue_valid", i), 32'(issue_valid), 32'(v.e_iv));
      check_output($sformatf("v%0d_count", i), 32'(count), 32'(v.e_cnt));
      check_output($sformatf("v%0d_disp_ready", i), 32'(disp_ready), 32'(v.e_cnt < DEPTH));
      if (v.e_iv) begin
        check_output($sformatf("v%0d_issue_rob", i), 32'(issue_rob_id), 32'(v.e_rob));
        check_output($sformatf("v%0d_issue_op", i), 32'(issue_op), 32'({4'h8, v.e_rob}));
        check_output($sformatf("v%0d_issue_vj", i), issue_Vj, v.e_vj);
        check_output($sformatf("v%0d_issue_vk", i), issue_Vk, v.e_vk);
      end
      @(posedge clk_in);
      #1;
    end

    // Fill to capacity, exercise the count==15 dispatch+issue case, then flush
    model_step(st(1, 1, 0, 0, 32'h100, 32'h101, 0, 2'b00, 0, 0, 0, 0), 1'b0);
    for (int r = 2; r < 16; r++)
      model_step(st(1, 4'(r), 1, 0, 32'(r), 32'(r), 0, 2'b00, 0, 0, 0, 0), 1'b0);
    check_output("fill15_count", 32'(count), 32'd15);
    check_output("fill15_one_vacancy", 32'(one_vacancy), 32'd1);
    check_output("fill15_full", 32'(full), 32'd0);
    model_step(st(1, 0, 1, 0, 32'h200, 32'h201, 1, 2'b00, 0, 0, 0, 0), 1'b0);
    check_output("disp_issue_at15_count", 32'(count), 32'd15);
    model_step(st(1, 5, 1, 0, 32'h300, 32'h301, 0, 2'b00, 0, 0, 0, 0), 1'b0);
    check_output("fill16_full", 32'(full), 32'd1);
    check_output("fill16_disp_ready", 32'(disp_ready), 32'd0);
    check_output("fill16_one_vacancy", 32'(one_vacancy), 32'd0);
    model_step(st(1, 6, 0, 0, 32'h400, 32'h401, 0, 2'b00, 0, 0, 0, 0), 1'b0);
    check_output("disp_when_full_count", 32'(count), 32'd16);
    model_step(st(0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 32'hBEEF, 0, 0), 1'b0);
    s = st(1, 7, 0, 0, 32'h500, 32'h501, 1, 2'b00, 0, 0, 0, 0);
    s.fl = 1'b1;
    model_step(s, 1'b0);
    check_output("flush_count", 32'(count), 32'd0);
    check_output("flush_issue_valid", 32'(issue_valid), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      s = rand_stim((n < 1500) ? 60 : 20);
      model_step(s, ($urandom_range(299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
